// File: rtl/ysyx_22041412_lsu_pkg.sv
// ysyx_22041412_lsu_pkg
//   Shared definitions for the load/store unit: FSM state encoding, fault
//   cause codes, RISC-V load/store funct3 encodings and a zero data word.
package ysyx_22041412_lsu_pkg;

  // DRAIN is the reset state; it clears any stale SRAM ready before IDLE.
  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_REQ   = 3'd2,
    ST_ACK   = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_FUNC3    = 2'd2,
    CAUSE_NULL     = 2'd3
  } lsu_cause_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [63:0] ysyx_22041412_zero_word = 64'd0;

endpackage

// File: rtl/ysyx_22041412_lsu_check.sv
// ysyx_22041412_lsu_check
//   Combinational fault check for one memory op.
//   Ports:
//     store_i  : 1 = store, 0 = load
//     func3_i  : RISC-V funct3 (size in [1:0], unsigned flag in [2])
//     addr_i   : effective address
//     fault_o  : any fault detected
//     cause_o  : fault cause, priority illegal func3 > misaligned > null load
import ysyx_22041412_lsu_pkg::*;

module ysyx_22041412_lsu_check #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  store_i,
  input  logic [2:0]            func3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  fault_o,
  output lsu_cause_e            cause_o
);

  logic func3_bad;
  logic misaligned;
  logic null_load;

  // Stores only have four sizes; loads accept everything except 3'b111.
  // Size is func3[1:0] for both loads and stores.
  always_comb begin
    if (store_i) begin
      func3_bad = !(func3_i inside {F3_SB, F3_SH, F3_SW, F3_SD});
    end else begin
      func3_bad = !(func3_i inside {F3_LB, F3_LH, F3_LW, F3_LD,
                                    F3_LBU, F3_LHU, F3_LWU});
    end

    unique case (func3_i[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_i[0];
      2'd2:    misaligned = |addr_i[1:0];
      default: misaligned = |addr_i[2:0];
    endcase

    // The SRAM never completes a load from address 0, so it must not be issued.
    null_load = !store_i && (addr_i == '0);

    if (func3_bad) begin
      cause_o = CAUSE_FUNC3;
    end else if (misaligned) begin
      cause_o = CAUSE_MISALIGN;
    end else if (null_load) begin
      cause_o = CAUSE_NULL;
    end else begin
      cause_o = CAUSE_NONE;
    end
    fault_o = (cause_o != CAUSE_NONE);
  end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// ysyx_22041412_lsu
//   Load/store unit between the MEM stage and the data SRAM port.
//   Ports:
//     req_*  : MEM-stage op (valid/ready handshake, store bit, func3, addr,
//              low-aligned store data, load destination register)
//     mem_*  : SRAM en/wen/func3/addr/wdata, ack (SRAM ready_i), ready, rdata
//     wb_*   : writeback result held until wb_ready_i (we, rd, data, fault, cause)
//     busy_o : high whenever the unit is not idle (pipeline stall)
//     load_cnt_o / store_cnt_o : completed non-faulting loads / stores
import ysyx_22041412_lsu_pkg::*;

module ysyx_22041412_lsu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_func3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  mem_en_o,
  output logic                  mem_wen_o,
  output logic [2:0]            mem_func3_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_ack_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic                  wb_we_o,
  output logic [4:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  wb_fault_o,
  output logic [1:0]            wb_cause_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  load_cnt_o,
  output logic [CNT_WIDTH-1:0]  store_cnt_o
);

  lsu_state_e            state_q, state_d;
  logic                  drain_ack_q, drain_ack_d;
  logic                  store_q, store_d;
  logic [2:0]            func3_q, func3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  lsu_cause_e            cause_q, cause_d;
  logic [CNT_WIDTH-1:0]  load_cnt_q, load_cnt_d;
  logic [CNT_WIDTH-1:0]  store_cnt_q, store_cnt_d;

  logic                  chk_fault;
  lsu_cause_e            chk_cause;

  // The check looks at the live request so the fault is known on acceptance.
  ysyx_22041412_lsu_check #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_check (
    .store_i (req_store_i),
    .func3_i (req_func3_i),
    .addr_i  (req_addr_i),
    .fault_o (chk_fault),
    .cause_o (chk_cause)
  );

  // Next-state logic. The DRAIN ack is a separate flop so it is only raised
  // after a stale ready has actually been seen, one clean cycle long.
  always_comb begin
    state_d     = state_q;
    drain_ack_d = 1'b0;
    store_d     = store_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    cause_d     = cause_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;

    unique case (state_q)
      ST_DRAIN: begin
        if (drain_ack_q) begin
          state_d = ST_IDLE;
        end else if (mem_ready_i) begin
          drain_ack_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid_i) begin
          store_d = req_store_i;
          func3_d = req_func3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rd_d    = req_rd_i;
          rdata_d = DATA_WIDTH'(ysyx_22041412_zero_word);
          cause_d = chk_cause;
          state_d = chk_fault ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          if (!store_q) begin
            rdata_d = mem_rdata_i;
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (wb_ready_i) begin
          state_d = ST_IDLE;
          if (cause_q == CAUSE_NONE) begin
            if (store_q) begin
              store_cnt_d = store_cnt_q + 1'b1;
            end else begin
              load_cnt_d = load_cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_DRAIN;
      end
    endcase
  end

  // All state, latched request fields and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DRAIN;
      drain_ack_q <= 1'b0;
      store_q     <= 1'b0;
      func3_q     <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 5'd0;
      rdata_q     <= '0;
      cause_q     <= CAUSE_NONE;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_ack_q <= drain_ack_d;
      store_q     <= store_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      cause_q     <= cause_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // Outputs decode only flops, so they never depend on inputs combinationally.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    mem_en_o    = (state_q == ST_REQ);
    mem_wen_o   = (state_q == ST_REQ) && store_q;
    mem_func3_o = func3_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_ack_o   = (state_q == ST_ACK) || ((state_q == ST_DRAIN) && drain_ack_q);
    wb_valid_o  = (state_q == ST_RESP);
    wb_we_o     = (state_q == ST_RESP) && !store_q && (cause_q == CAUSE_NONE);
    wb_rd_o     = rd_q;
    wb_data_o   = rdata_q;
    wb_fault_o  = (state_q == ST_RESP) && (cause_q != CAUSE_NONE);
    wb_cause_o  = (state_q == ST_RESP) ? cause_q : CAUSE_NONE;
    load_cnt_o  = load_cnt_q;
    store_cnt_o = store_cnt_q;
  end

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// tb_ysyx_22041412_lsu
//   Self-checking bench: a small SRAM model, a per-op expectation queue and a
//   negedge compare process, driven by directed cases and random ops.
module tb_ysyx_22041412_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [2:0]  req_func3_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_en_o;
  logic        mem_wen_o;
  logic [2:0]  mem_func3_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ack_o;
  logic        mem_ready_i;
  logic [63:0] mem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic        wb_fault_o;
  logic [1:0]  wb_cause_o;
  logic        busy_o;
  logic [31:0] load_cnt_o;
  logic [31:0] store_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  ysyx_22041412_lsu #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_store_i(req_store_i), .req_func3_i(req_func3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_func3_o(mem_func3_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_o(mem_ack_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_we_o(wb_we_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_fault_o(wb_fault_o),
    .wb_cause_o(wb_cause_o), .busy_o(busy_o),
    .load_cnt_o(load_cnt_o), .store_cnt_o(store_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // SRAM model: ready rises once en has been held sram_wait cycles, then stays
  // up until acknowledged. It has no reset; rdy_hold starts set to mimic a
  // stale ready at power-up, and force_stuck lets a test pin ready high.
  int          sram_wait = 0;
  logic [63:0] sram_rdata = 64'd0;
  int          en_cnt = 0;
  logic        rdy_hold = 1'b1;
  logic        force_stuck = 1'b0;

  always_comb begin
    mem_ready_i = rdy_hold | (mem_en_o && (en_cnt >= sram_wait));
    mem_rdata_i = sram_rdata;
  end

  always @(posedge clk) begin
    en_cnt <= mem_en_o ? en_cnt + 1 : 0;
    if (mem_ack_o) rdy_hold <= 1'b0;
    else if (force_stuck || mem_ready_i) rdy_hold <= 1'b1;
  end

  // Writeback backpressure: 0 = always ready, 1 = random, 2 = held off.
  int wb_ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (wb_ready_mode)
      0:       wb_ready_i = 1'b1;
      1:       wb_ready_i = ($urandom_range(0, 9) < 7);
      default: wb_ready_i = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Reference rules: legal func3, natural alignment, no load from address 0.
  function automatic logic [1:0] modelCause(input logic st, input logic [2:0] f3, input logic [63:0] addr);
    int size;
    if (st ? (f3 > 3'd3) : (f3 == 3'd7)) return 2'd2;
    size = 1 << f3[1:0];
    if ((addr % 64'(size)) != 64'd0) return 2'd1;
    if (!st && addr == 64'd0) return 2'd3;
    return 2'd0;
  endfunction

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    int          wt;
    logic [63:0] rdata;
    logic [1:0]  cause;
    int          acc;
    int          acks;
    bit          seen;
  } op_t;

  op_t         q[$];
  logic [31:0] exp_loads = 0;
  logic [31:0] exp_stores = 0;

  // Compare process: every cycle, outputs against the expectation queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_loads = 0;
      exp_stores = 0;
      checkOutput("rst_mem_en", 64'(mem_en_o), 64'd0);
      checkOutput("rst_mem_ack", 64'(mem_ack_o), 64'd0);
      checkOutput("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
      checkOutput("rst_load_cnt", 64'(load_cnt_o), 64'd0);
      checkOutput("rst_store_cnt", 64'(store_cnt_o), 64'd0);
    end else begin
      checkOutput("en_ack_excl", 64'(mem_en_o & mem_ack_o), 64'd0);
      checkOutput("busy_vs_ready", 64'(busy_o), 64'(!req_ready_o));
      checkOutput("load_cnt", 64'(load_cnt_o), 64'(exp_loads));
      checkOutput("store_cnt", 64'(store_cnt_o), 64'(exp_stores));
      if (mem_en_o) begin
        if (q.size() == 0) begin
          checkOutput("en_without_op", 64'd1, 64'd0);
        end else begin
          checkOutput("en_on_fault", 64'(q[0].cause), 64'd0);
          checkOutput("mem_wen", 64'(mem_wen_o), 64'(q[0].store));
          checkOutput("mem_func3", 64'(mem_func3_o), 64'(q[0].f3));
          checkOutput("mem_addr", mem_addr_o, q[0].addr);
          checkOutput("mem_wdata", mem_wdata_o, q[0].wdata);
        end
      end
      if (mem_ack_o && q.size() != 0) q[0].acks++;
      if (wb_valid_o) begin
        if (q.size() == 0) begin
          checkOutput("valid_without_op", 64'd1, 64'd0);
        end else begin
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            checkOutput("latency", 64'(cycle - q[0].acc),
                        64'((q[0].cause != 0) ? 1 : 3 + q[0].wt));
          end
          checkOutput("wb_we", 64'(wb_we_o), 64'(!q[0].store && q[0].cause == 0));
          checkOutput("wb_rd", 64'(wb_rd_o), 64'(q[0].rd));
          checkOutput("wb_data", wb_data_o,
                      (!q[0].store && q[0].cause == 0) ? q[0].rdata : 64'd0);
          checkOutput("wb_fault", 64'(wb_fault_o), 64'(q[0].cause != 0));
          checkOutput("wb_cause", 64'(wb_cause_o), 64'(q[0].cause));
          if (wb_ready_i) begin
            checkOutput("ack_pulses", 64'(q[0].acks), 64'((q[0].cause == 0) ? 1 : 0));
            if (q[0].cause == 0) begin
              if (q[0].store) exp_stores = exp_stores + 1;
              else exp_loads = exp_loads + 1;
            end
            void'(q.pop_front());
          end
        end
      end
      if (req_valid_i && req_ready_o) begin
        op_t o;
        o.store = req_store_i;
        o.f3    = req_func3_i;
        o.addr  = req_addr_i;
        o.wdata = req_wdata_i;
        o.rd    = req_rd_i;
        o.wt    = sram_wait;
        o.rdata = sram_rdata;
        o.cause = modelCause(req_store_i, req_func3_i, req_addr_i);
        o.acc   = cycle;
        o.acks  = 0;
        o.seen  = 1'b0;
        q.push_back(o);
      end
    end
  end

  // Presents one op and returns once it has been accepted.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [4:0] rd, input int wt,
                       input logic [63:0] rdata, output int acc);
    @(posedge clk);
    #1;
    sram_wait   = wt;
    sram_rdata  = rdata;
    req_store_i = st;
    req_func3_i = f3;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_rd_i    = rd;
    req_valid_i = 1'b1;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = cycle;
        break;
      end
    end
    if (acc < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic waitValid(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_valid_o) begin
        lat = cycle - acc;
        return;
      end
    end
    checkOutput("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitDone();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [4:0] rd, input int wt,
                               input logic [63:0] rdata);
    int acc;
    issue(st, f3, addr, wdata, rd, wt, rdata, acc);
    waitDone();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, lat, acks, ens, hs, acc2;
    logic st;
    logic [2:0] f3;
    logic [63:0] addr;

    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_store_i = 1'b0;
    req_func3_i = 3'd0;
    req_addr_i  = 64'd0;
    req_wdata_i = 64'd0;
    req_rd_i    = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Power-up stale ready must be drained by exactly one ack.
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acks += int'(mem_ack_o);
    end
    checkOutput("powerup_drain_acks", 64'(acks), 64'd1);
    checkOutput("powerup_idle_ready", 64'(req_ready_o), 64'd1);

    $display("[TB] load hit");
    issue(1'b0, 3'd3, 64'h8000_0008, 64'd0, 5'd5, 0, 64'h1122_3344_5566_7788, acc);
    waitValid(acc, lat);
    checkOutput("ld_latency", 64'(lat), 64'd3);
    checkOutput("ld_we", 64'(wb_we_o), 64'd1);
    checkOutput("ld_data", wb_data_o, 64'h1122_3344_5566_7788);
    checkOutput("ld_rd", 64'(wb_rd_o), 64'd5);
    waitDone();
    checkOutput("ld_load_cnt", 64'(load_cnt_o), 64'd1);

    $display("[TB] store");
    issue(1'b1, 3'd2, 64'h8000_0004, 64'hDEAD_BEEF, 5'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    @(negedge clk);
    checkOutput("st_en", 64'(mem_en_o), 64'd1);
    checkOutput("st_wen", 64'(mem_wen_o), 64'd1);
    checkOutput("st_func3", 64'(mem_func3_o), 64'd2);
    checkOutput("st_wdata", mem_wdata_o, 64'hDEAD_BEEF);
    waitValid(acc, lat);
    checkOutput("st_we", 64'(wb_we_o), 64'd0);
    checkOutput("st_fault", 64'(wb_fault_o), 64'd0);
    checkOutput("st_data", wb_data_o, 64'd0);
    waitDone();
    checkOutput("st_store_cnt", 64'(store_cnt_o), 64'd1);

    $display("[TB] faults");
    issue(1'b0, 3'd1, 64'h8000_0001, 64'd0, 5'd3, 0, 64'd7, acc);
    waitValid(acc, lat);
    checkOutput("mis_latency", 64'(lat), 64'd1);
    checkOutput("mis_fault", 64'(wb_fault_o), 64'd1);
    checkOutput("mis_cause", 64'(wb_cause_o), 64'd1);
    waitDone();
    issue(1'b0, 3'd2, 64'd0, 64'd0, 5'd4, 0, 64'd7, acc);
    waitValid(acc, lat);
    checkOutput("null_cause", 64'(wb_cause_o), 64'd3);
    waitDone();
    issue(1'b1, 3'd5, 64'h8000_0000, 64'd9, 5'd0, 0, 64'd7, acc);
    waitValid(acc, lat);
    checkOutput("f3_cause", 64'(wb_cause_o), 64'd2);
    checkOutput("f3_we", 64'(wb_we_o), 64'd0);
    waitDone();
    checkOutput("fault_load_cnt", 64'(load_cnt_o), 64'd1);
    checkOutput("fault_store_cnt", 64'(store_cnt_o), 64'd1);

    $display("[TB] backpressure");
    wb_ready_mode = 2;
    issue(1'b0, 3'd3, 64'h8000_0010, 64'd0, 5'd7, 1, 64'hCAFE_F00D_1234_5678, acc);
    waitValid(acc, lat);
    checkOutput("bp_latency", 64'(lat), 64'd4);
    #1;
    req_store_i = 1'b1;
    req_func3_i = 3'd3;
    req_addr_i  = 64'h8000_0018;
    req_wdata_i = 64'h0123_4567_89AB_CDEF;
    req_rd_i    = 5'd0;
    sram_wait   = 0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_data", wb_data_o, 64'hCAFE_F00D_1234_5678);
      checkOutput("bp_rd", 64'(wb_rd_o), 64'd7);
      checkOutput("bp_req_ready", 64'(req_ready_o), 64'd0);
      checkOutput("bp_busy", 64'(busy_o), 64'd1);
    end
    wb_ready_mode = 0;
    hs = -1;
    acc2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_valid_o && wb_ready_i && hs < 0) hs = cycle;
      if (req_ready_o) begin
        acc2 = cycle;
        break;
      end
    end
    checkOutput("bp_accept_after_hs", 64'(acc2 - hs), 64'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    waitDone();
    checkOutput("bp_load_cnt", 64'(load_cnt_o), 64'd2);
    checkOutput("bp_store_cnt", 64'(store_cnt_o), 64'd2);

    $display("[TB] reset mid-request");
    issue(1'b0, 3'd3, 64'h8000_0020, 64'd0, 5'd9, 50, 64'd1, acc);
    @(negedge clk);
    #1;
    force_stuck = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 force_stuck = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sram_wait = 0;
    acks = 0;
    ens = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acks += int'(mem_ack_o);
      ens += int'(mem_en_o);
    end
    checkOutput("rst_drain_acks", 64'(acks), 64'd1);
    checkOutput("rst_drain_en", 64'(ens), 64'd0);
    checkOutput("rst_idle_ready", 64'(req_ready_o), 64'd1);
    checkOutput("rst_ready_cleared", 64'(mem_ready_i), 64'd0);
    applyStimulus(1'b0, 3'd6, 64'h8000_0024, 64'd0, 5'd11, 0, 64'h0000_0000_8765_4321);
    checkOutput("post_rst_load_cnt", 64'(load_cnt_o), 64'd1);

    $display("[TB] random ops");
    wb_ready_mode = 1;
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      addr = 64'h8000_0000 + 64'($urandom & 32'h0000_FFF8);
      if ($urandom_range(0, 3) == 0) addr = addr + 64'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) addr = 64'd0;
      applyStimulus(st, f3, addr, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wb_ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
